// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encoding,
// slice width and a helper for sizing the slice index.
package cmp_pkg;

  // Controller states; encodings are fixed so checkers can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of one comparison slice (matches the shared 2-bit comparator).
  localparam int SLICE_W = 2;

  // Bits needed to hold a slice index 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : cmp_pkg

// File: rtl/cmp2b.sv
// Two-bit unsigned magnitude comparator shared by the serial controller.
// Purely combinational; exactly one of eq/lt/gt is high for any input.
module cmp2b (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq,
  output logic       lt,
  output logic       gt
);

  // Direct unsigned compare of the two slices.
  always_comb begin
    eq = (a == b);
    lt = (a <  b);
    gt = (a >  b);
  end

endmodule : cmp2b

// File: rtl/cmp_serial_ctrl.sv
// Sequential magnitude comparator: walks the operands from the most
// significant 2-bit slice down, one slice per cycle, and stops at the first
// slice that differs.
//
// Handshake: start is sampled only in IDLE or DONE. On acceptance a/b are
// captured and busy rises the next cycle. done is a single-cycle pulse in the
// DONE state; eq/lt/gt are valid from that cycle and hold until the next
// accepted start clears them. A start held high through DONE is accepted
// back-to-back; a start seen while busy is ignored.
module cmp_serial_ctrl
  import cmp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         lt,
  output logic         gt
);

  localparam int N  = W / SLICE_W;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] K_TOP = IW'(N - 1);

  // Odd or too-narrow operands cannot be split into 2-bit slices.
  if (((W % SLICE_W) != 0) || (W < SLICE_W)) begin : g_bad_width
    $fatal(1, "cmp_serial_ctrl: W must be even and >= 2");
  end

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [IW-1:0] k_q, k_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;
  logic          gt_q, gt_d;

  logic [SLICE_W-1:0] sl_a, sl_b;
  logic               sl_eq, sl_lt, sl_gt;
  logic               accept;

  // Select the slice addressed by the current index from the latched operands.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == IW'(i)) begin
        sl_a = a_q[i*SLICE_W +: SLICE_W];
        sl_b = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  cmp2b u_cmp2b (
    .a  (sl_a),
    .b  (sl_b),
    .eq (sl_eq),
    .lt (sl_lt),
    .gt (sl_gt)
  );

  // Next-state, operand capture, index stepping and result flag updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    accept  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          a_d     = a;
          b_d     = b;
          k_d     = K_TOP;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = ST_CMP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CMP: begin
        if (sl_gt) begin
          gt_d    = 1'b1;
          state_d = ST_DONE;
        end else if (sl_lt) begin
          lt_d    = 1'b1;
          state_d = ST_DONE;
        end else if (k_q == '0) begin
          // All slices matched down to the least significant one.
          eq_d    = sl_eq;
          state_d = ST_DONE;
        end else begin
          k_d = k_q - IW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  // Status is decoded from registered state only.
  always_comb begin
    busy = (state_q == ST_CMP);
    done = (state_q == ST_DONE);
    eq   = eq_q;
    lt   = lt_q;
    gt   = gt_q;
  end

  // accept is kept as a named decode for probing the handshake.
  logic unused_accept;
  assign unused_accept = accept;

endmodule : cmp_serial_ctrl

// File: tb/tb_cmp_serial_ctrl.sv
// Directed bench for cmp_serial_ctrl (W=8). Drivers push the expected
// {eq,lt,gt} and the expected done cycle into queues; a monitor pops and
// checks whenever done is seen, and checks flags are clear while busy.
module tb_cmp_serial_ctrl;

  localparam int W = 8;
  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_LT = 3'b010;
  localparam logic [2:0] F_GT = 3'b001;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         eq;
  logic         lt;
  logic         gt;

  int n_cmp;
  int n_bad;
  int cyc;

  logic [2:0] exp_q[$];
  int         exp_cyc_q[$];

  cmp_serial_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .lt    (lt),
    .gt    (gt)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pop on done, flags-clear check while busy.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done seen with no pending request (cycle %0d)", cyc);
      end else begin
        check("result_flags", {29'd0, eq, lt, gt}, {29'd0, exp_q.pop_front()});
        check("done_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
    if (busy) begin
      check("flags_clear_while_busy", {29'd0, eq, lt, gt}, 32'd0);
    end
  end

  // Driver: present one request; called at posedge+1 with the DUT idle/done.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [2:0] ef, input int n, input bit push);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(posedge clk); #1;
    start = 1'b0;
    a     = W'($urandom_range(0, 255));
    b     = W'($urandom_range(0, 255));
    if (push) begin
      exp_q.push_back(ef);
      exp_cyc_q.push_back(cyc + n);
    end
  endtask

  // Wait until all expected results are consumed and the DUT is idle.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state; start asserted to show reset wins.
    repeat (2) @(posedge clk);
    start = 1'b1;
    a = 8'h12;
    b = 8'h34;
    @(posedge clk); #1;
    check("reset_outputs", {27'd0, busy, done, eq, lt, gt}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", {27'd0, busy, done, eq, lt, gt}, 32'd0);

    // Equal operands: worst case, four slices.
    issue(8'hA5, 8'hA5, F_EQ, 4, 1'b1);
    wait_idle();
    check("eq_held_in_idle", {28'd0, busy, eq, lt, gt}, {28'd0, 1'b0, F_EQ});

    // Top slice decides.
    issue(8'h80, 8'h7F, F_GT, 1, 1'b1);
    wait_idle();
    check("gt_held_in_idle", {29'd0, eq, lt, gt}, {29'd0, F_GT});

    // Difference only in slice 0.
    issue(8'h34, 8'h36, F_LT, 4, 1'b1);
    wait_idle();

    // Middle-slice decisions and other patterns.
    issue(8'h0C, 8'h08, F_GT, 3, 1'b1);
    wait_idle();
    issue(8'h2C, 8'h1C, F_GT, 2, 1'b1);
    wait_idle();
    issue(8'h40, 8'h80, F_LT, 1, 1'b1);
    wait_idle();
    issue(8'h12, 8'h13, F_LT, 4, 1'b1);
    wait_idle();
    issue(8'hFF, 8'hFF, F_EQ, 4, 1'b1);
    wait_idle();
    issue(8'h00, 8'h00, F_EQ, 4, 1'b1);
    wait_idle();

    // Start while busy is ignored.
    issue(8'h00, 8'hFF, F_LT, 1, 1'b1);
    start = 1'b1;
    a = 8'h00;
    b = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (6) @(posedge clk);
    check("no_extra_done_after_ignored_start", {29'd0, eq, lt, gt}, {29'd0, F_LT});

    // Reset during CMP aborts with no done pulse.
    issue(8'h5A, 8'h5A, F_EQ, 4, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_abort_outputs", {27'd0, busy, done, eq, lt, gt}, 32'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("idle_after_abort", {27'd0, busy, done, eq, lt, gt}, 32'd0);

    // Back-to-back: start held through DONE with new operands.
    begin
      int t_acc;
      start = 1'b1;
      a = 8'hA5;
      b = 8'hA5;
      @(posedge clk); #1;
      exp_q.push_back(F_EQ);
      exp_cyc_q.push_back(cyc + 4);
      a = 8'h01;
      b = 8'h00;
      repeat (4) @(posedge clk);
      #1;
      check("b2b_first_done_visible", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      t_acc = cyc;
      start = 1'b0;
      exp_q.push_back(F_GT);
      exp_cyc_q.push_back(t_acc + 4);
      check("b2b_busy_after_accept", {31'd0, busy}, 32'd1);
      wait_idle();
    end

    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_cmp_serial_ctrl
